// File: rtl/timing_cfg_ctrl_if.sv
// rtl/timing_cfg_ctrl_if.sv - shadow-write, commit and active-timing bundle for timing_cfg_ctrl
interface timing_cfg_ctrl_if;
  logic        I_wr_en;
  logic [3:0]  I_wr_addr;
  logic [15:0] I_wr_data;
  logic        I_commit;
  logic        I_vb;

  logic [15:0] O_h_total;
  logic [15:0] O_h_sync;
  logic [15:0] O_h_bporch;
  logic [15:0] O_h_res;
  logic [15:0] O_v_total;
  logic [15:0] O_v_sync;
  logic [15:0] O_v_bporch;
  logic [15:0] O_v_res;
  logic        O_hs_pol;
  logic        O_vs_pol;
  logic        O_gen_rst_n;
  logic        O_busy;
  logic        O_cfg_err;

  modport master (
    output I_wr_en, I_wr_addr, I_wr_data, I_commit, I_vb,
    input  O_h_total, O_h_sync, O_h_bporch, O_h_res,
    input  O_v_total, O_v_sync, O_v_bporch, O_v_res,
    input  O_hs_pol, O_vs_pol, O_gen_rst_n, O_busy, O_cfg_err
  );

  modport slave (
    input  I_wr_en, I_wr_addr, I_wr_data, I_commit, I_vb,
    output O_h_total, O_h_sync, O_h_bporch, O_h_res,
    output O_v_total, O_v_sync, O_v_bporch, O_v_res,
    output O_hs_pol, O_vs_pol, O_gen_rst_n, O_busy, O_cfg_err
  );
endinterface

// File: rtl/timing_cfg_ctrl.sv
// rtl/timing_cfg_ctrl.sv - shadowed video timing set, applied in vertical blank with generator reset; optional commit check via TIMING_CFG_VALIDATE_EN
module timing_cfg_ctrl #(
  parameter int unsigned RST_HOLD = 4,
  parameter logic [19:0] WAIT_MAX = 20'hFFFFF
) (
  input logic              I_pxl_clk,
  input logic              I_rst_n,
  timing_cfg_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_VB, S_APPLY, S_HOLD} state_t;

  // 1280x720 timing: h_total, h_sync, h_bporch, h_res, v_total, v_sync, v_bporch, v_res
  localparam logic [15:0] DEF_TIMING [8] = '{16'd1650, 16'd40, 16'd220, 16'd1280,
                                             16'd750,  16'd5,  16'd20,  16'd720};
  localparam logic [7:0]  HOLD_LAST = 8'(RST_HOLD - 1);

  state_t      state, state_nx;
  logic [15:0] sh_t  [8];
  logic [1:0]  sh_pol;
  logic [15:0] act_t [8];
  logic [1:0]  act_pol;
  logic        vb_q;
  logic [19:0] wait_cnt;
  logic [19:0] wait_inc;
  logic [7:0]  hold_cnt;
  logic        gen_rst_n_q;
  logic        busy_q;
  logic        commit_ok;
  logic        commit_go;
  logic        vb_rise;

`ifdef TIMING_CFG_VALIDATE_EN
  logic [17:0] h_sum;
  logic [17:0] v_sum;
  logic        cfg_err_q;

  // Commit check on the shadow set; 18-bit sums leave headroom for three 16-bit terms
  always_comb begin
    h_sum     = {2'b00, sh_t[1]} + {2'b00, sh_t[2]} + {2'b00, sh_t[3]};
    v_sum     = {2'b00, sh_t[5]} + {2'b00, sh_t[6]} + {2'b00, sh_t[7]};
    commit_ok = (sh_t[0] != 16'd0) && (sh_t[4] != 16'd0) &&
                (h_sum <= {2'b00, sh_t[0]}) && (v_sum <= {2'b00, sh_t[4]});
  end

  // Sticky error: set by a rejected commit, cleared when a good set is applied
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      cfg_err_q <= 1'b0;
    end else if (state == S_IDLE && bus.I_commit && !commit_ok) begin
      cfg_err_q <= 1'b1;
    end else if (state == S_APPLY) begin
      cfg_err_q <= 1'b0;
    end
  end

  assign bus.O_cfg_err = cfg_err_q;
`else
  assign commit_ok     = 1'b1;
  assign bus.O_cfg_err = 1'b0;
`endif

  assign commit_go = (state == S_IDLE) && bus.I_commit && commit_ok;
  assign vb_rise   = bus.I_vb && !vb_q;
  assign wait_inc  = (wait_cnt == 20'hFFFFF) ? wait_cnt : wait_cnt + 20'd1;

  // State register; reset lands in HOLD so the generator restarts in the default mode
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) state <= S_HOLD;
    else          state <= state_nx;
  end

  // Next-state decode; WAIT_VB leaves on a blank rising edge or once WAIT_MAX cycles have elapsed
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (commit_go) state_nx = S_WAIT_VB;
      S_WAIT_VB: if (vb_rise || wait_inc >= WAIT_MAX) state_nx = S_APPLY;
      S_APPLY:   state_nx = S_HOLD;
      S_HOLD:    if (hold_cnt == HOLD_LAST) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Blank edge detector and the saturating wait / hold counters
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      vb_q     <= 1'b0;
      wait_cnt <= 20'd0;
      hold_cnt <= 8'd0;
    end else begin
      vb_q     <= bus.I_vb;
      wait_cnt <= (state == S_WAIT_VB) ? wait_inc : 20'd0;
      hold_cnt <= (state == S_HOLD) ? hold_cnt + 8'd1 : 8'd0;
    end
  end

  // Shadow registers accept writes in every state; addresses 9-15 fall through
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      for (int i = 0; i < 8; i++) sh_t[i] <= DEF_TIMING[i];
      sh_pol <= 2'b11;
    end else if (bus.I_wr_en) begin
      if (!bus.I_wr_addr[3])             sh_t[bus.I_wr_addr[2:0]] <= bus.I_wr_data;
      else if (bus.I_wr_addr == 4'd8)    sh_pol <= bus.I_wr_data[1:0];
    end
  end

  // Active set loads from the pre-edge shadow, so a write in the APPLY cycle stays pending
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      for (int i = 0; i < 8; i++) act_t[i] <= DEF_TIMING[i];
      act_pol <= 2'b11;
    end else if (state == S_APPLY) begin
      for (int i = 0; i < 8; i++) act_t[i] <= sh_t[i];
      act_pol <= sh_pol;
    end
  end

  // Generator reset and busy come from flops so the downstream reset never glitches
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      gen_rst_n_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      gen_rst_n_q <= !(state_nx == S_APPLY || state_nx == S_HOLD);
      busy_q      <= (state_nx != S_IDLE);
    end
  end

  assign bus.O_h_total   = act_t[0];
  assign bus.O_h_sync    = act_t[1];
  assign bus.O_h_bporch  = act_t[2];
  assign bus.O_h_res     = act_t[3];
  assign bus.O_v_total   = act_t[4];
  assign bus.O_v_sync    = act_t[5];
  assign bus.O_v_bporch  = act_t[6];
  assign bus.O_v_res     = act_t[7];
  assign bus.O_hs_pol    = act_pol[0];
  assign bus.O_vs_pol    = act_pol[1];
  assign bus.O_gen_rst_n = gen_rst_n_q;
  assign bus.O_busy      = busy_q;

endmodule

// File: tb/tb_timing_cfg_ctrl.sv
// tb/tb_timing_cfg_ctrl.sv - randomized directed bench for timing_cfg_ctrl against a register-map model
module tb_timing_cfg_ctrl;
  localparam int RST_HOLD = 4;
  localparam int WAIT_MAX = 1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  timing_cfg_ctrl_if bus ();

  timing_cfg_ctrl #(.RST_HOLD(RST_HOLD), .WAIT_MAX(20'(WAIT_MAX))) dut (
    .I_pxl_clk (clk),
    .I_rst_n   (rst_n),
    .bus       (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int defaults [9] = '{1650, 40, 220, 1280, 750, 5, 20, 720, 3};
  int shadow   [9];
  int active   [9];
  bit exp_err;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int dut_out(int i);
    case (i)
      0: return int'(bus.O_h_total);
      1: return int'(bus.O_h_sync);
      2: return int'(bus.O_h_bporch);
      3: return int'(bus.O_h_res);
      4: return int'(bus.O_v_total);
      5: return int'(bus.O_v_sync);
      6: return int'(bus.O_v_bporch);
      7: return int'(bus.O_v_res);
      default: return int'({bus.O_vs_pol, bus.O_hs_pol});
    endcase
  endfunction

  function automatic bit model_valid();
`ifdef TIMING_CFG_VALIDATE_EN
    return shadow[0] != 0 && shadow[4] != 0 &&
           shadow[1] + shadow[2] + shadow[3] <= shadow[0] &&
           shadow[5] + shadow[6] + shadow[7] <= shadow[4];
`else
    return 1'b1;
`endif
  endfunction

  function automatic void model_write(int a, int d);
    if (a == 8)      shadow[8] = d & 3;
    else if (a < 8)  shadow[a] = d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.I_wr_en   = 1'b0;
    bus.I_wr_addr = 4'd0;
    bus.I_wr_data = 16'd0;
    bus.I_commit  = 1'b0;
    bus.I_vb      = 1'b0;
  endtask

  task automatic check_active(string tag);
    for (int i = 0; i < 9; i++)
      check($sformatf("%s_%0d", tag, i), dut_out(i), active[i]);
  endtask

  task automatic wr(int a, int d);
    bus.I_wr_en   = 1'b1;
    bus.I_wr_addr = 4'(a);
    bus.I_wr_data = 16'(d);
    tick();
    bus.I_wr_en   = 1'b0;
    model_write(a, d);
  endtask

  task automatic write_random_set();
    int ht, hs, hb, vt, vs, vb;
    ht = $urandom_range(100, 4000);
    hs = $urandom_range(1, ht / 4);
    hb = $urandom_range(0, ht / 4);
    vt = $urandom_range(100, 2000);
    vs = $urandom_range(1, vt / 4);
    vb = $urandom_range(0, vt / 4);
    wr(0, ht); wr(1, hs); wr(2, hb); wr(3, $urandom_range(1, ht - hs - hb));
    wr(4, vt); wr(5, vs); wr(6, vb); wr(7, $urandom_range(1, vt - vs - vb));
    wr(8, $urandom_range(0, 3));
    wr($urandom_range(9, 15), $urandom_range(0, 65535));
  endtask

  task automatic reset_seq();
    int cnt;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    shadow  = defaults;
    active  = defaults;
    exp_err = 1'b0;
    check_active("rst");
    check("rst_grst", bus.O_gen_rst_n, 1'b0);
    check("rst_busy", bus.O_busy, 1'b1);
    check("rst_err", bus.O_cfg_err, 1'b0);
    tick();
    rst_n = 1'b1;
    cnt = 0;
    while (bus.O_gen_rst_n !== 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    check("rst_hold_len", cnt, RST_HOLD);
    check("rst_busy_off", bus.O_busy, 1'b0);
    check_active("rst_rel");
  endtask

  task automatic do_switch(int d, bit late_wr, bit abort_hold);
    int n, cnt, a, dat, exp_lat;
    bit w, applied;
    int snap [9];
    bit ok;
    ok = model_valid();
    bus.I_commit = 1'b1;
    tick();
    bus.I_commit = 1'b0;
    if (!ok) begin
      exp_err = 1'b1;
      check("rej_err", bus.O_cfg_err, 1'b1);
      check("rej_busy", bus.O_busy, 1'b0);
      check_active("rej_act");
      tick();
      check("rej_busy2", bus.O_busy, 1'b0);
      check("rej_grst", bus.O_gen_rst_n, 1'b1);
      return;
    end
    check("wait_busy", bus.O_busy, 1'b1);
    check("wait_grst", bus.O_gen_rst_n, 1'b1);
    check("wait_err", bus.O_cfg_err, exp_err);
    n = 0;
    applied = 1'b0;
    while (!applied && n < WAIT_MAX + 50) begin
      w   = ($urandom_range(0, 3) == 0);
      a   = $urandom_range(0, 15);
      dat = $urandom_range(0, 65535);
      bus.I_wr_en   = w;
      bus.I_wr_addr = 4'(a);
      bus.I_wr_data = 16'(dat);
      bus.I_commit  = (n == 1) || ($urandom_range(0, 15) == 0);
      bus.I_vb      = (n == d);
      tick();
      n++;
      if (w) model_write(a, dat);
      if (bus.O_gen_rst_n === 1'b0) applied = 1'b1;
    end
    idle_inputs();
    exp_lat = (d + 1 < WAIT_MAX) ? d + 1 : WAIT_MAX;
    check("apply_lat", n, exp_lat);
    check_active("apply_old");
    snap = shadow;
    a   = $urandom_range(0, 8);
    dat = $urandom_range(0, 65535);
    if (late_wr) begin
      bus.I_wr_en   = 1'b1;
      bus.I_wr_addr = 4'(a);
      bus.I_wr_data = 16'(dat);
    end
    tick();
    bus.I_wr_en = 1'b0;
    if (late_wr) model_write(a, dat);
    active  = snap;
    exp_err = 1'b0;
    check_active("apply_new");
    check("apply_err", bus.O_cfg_err, 1'b0);
    check("hold_grst", bus.O_gen_rst_n, 1'b0);
    if (abort_hold) begin
      #1;
      reset_seq();
      return;
    end
    cnt = 1;
    while (bus.O_gen_rst_n !== 1'b1 && cnt < 300) begin
      tick();
      cnt++;
    end
    check("hold_len", cnt, RST_HOLD + 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_busy", bus.O_busy, 1'b0);
    end
    check_active("idle_act");
  endtask

  initial begin
    idle_inputs();
    #2;
    reset_seq();

    wr(3, 640);
    do_switch(99, 1'b0, 1'b0);

    do_switch(5000, 1'b0, 1'b0);

    wr(3, 1700);
    do_switch(10, 1'b0, 1'b0);
    wr(3, 1280);
    do_switch(20, 1'b0, 1'b0);

    do_switch(30, 1'b1, 1'b0);
    do_switch(40, 1'b0, 1'b0);

    do_switch(0, 1'b0, 1'b0);

    do_switch(7, 1'b0, 1'b1);

    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 3) != 0) write_random_set();
      else wr($urandom_range(0, 15), $urandom_range(0, 65535));
      do_switch($urandom_range(0, 1100), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
